// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//
// Purpose:
//   Load/store initiator for the data port of a byte-addressed, word-wide
//   dual-port RAM. One RV32I load or store is in flight at a time. All RAM
//   accesses are word aligned. The RAM can only write whole words, so a
//   sub-word store (SB/SH) first reads the target word. It then merges the
//   new bytes into that word and writes the full word back. Load data is
//   returned to the CPU already extracted and sign- or zero-extended.
//
// Parameters:
//   MEM_BYTES   RAM size in bytes; any address >= MEM_BYTES is an error
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready CPU request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I funct3 of the access
//   req_addr            byte address
//   req_wdata           store data (low bits for SB/SH)
//   resp_valid/ready    response handshake; response held until accepted
//   resp_rdata          load result (zero for stores and errors)
//   resp_err            misaligned / illegal funct3 / out-of-range address
//   mem_en, mem_wr      RAM data-port enable and write strobe
//   mem_addr            RAM word address as a byte address, low bits zero
//   mem_wdata           RAM write word
//   mem_data            RAM read word, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Decide whether a request is rejected without touching memory.
    function automatic logic req_error(input logic        we,
                                       input logic [2:0]  f3,
                                       input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        if (addr >= 32'(MEM_BYTES)) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        case (f3)
            F3_B: begin
                bad = bad | 1'b0;
            end
            F3_BU: begin
                bad = bad | we;
            end
            F3_H: begin
                bad = bad | addr[0];
            end
            F3_HU: begin
                bad = bad | we | addr[0];
            end
            F3_W: begin
                bad = bad | (addr[1:0] != 2'b00);
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        return bad;
    endfunction

    // Extract and extend the addressed byte or halfword of a read word.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            F3_W:    res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Merge store data into the old word (the whole word for SW).
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] res;
        res = old_word;
        case (f3)
            F3_B: begin
                case (off)
                    2'd0:    res = {old_word[31:8], wdata[7:0]};
                    2'd1:    res = {old_word[31:16], wdata[7:0], old_word[7:0]};
                    2'd2:    res = {old_word[31:24], wdata[7:0], old_word[15:0]};
                    2'd3:    res = {wdata[7:0], old_word[23:0]};
                    default: res = old_word;
                endcase
            end
            F3_H: begin
                if (off[1]) begin
                    res = {wdata[15:0], old_word[15:0]};
                end else begin
                    res = {old_word[31:16], wdata[15:0]};
                end
            end
            F3_W: begin
                res = wdata;
            end
            default: begin
                res = old_word;
            end
        endcase
        return res;
    endfunction

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Next-state logic for the access sequencer and captured request.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rword_d = rword_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0000_0000;
                    if (req_error(req_we, req_funct3, req_addr)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        err_d   = 1'b0;
                        state_d = S_WR;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // The RAM holds its output while mem_en is low.
                rword_d = mem_data;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_extract(mem_data, f3_q, addr_q[1:0]);
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rword_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs depend only on the state and captured registers. An async
    // reset therefore drops mem_en/mem_wr in the same cycle.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_en     = (state_q == S_RD) || (state_q == S_WR);
    assign mem_wr     = (state_q == S_WR);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = (state_q == S_WR) ?
                        store_merge(rword_q, wdata_q, f3_q, addr_q[1:0]) :
                        32'h0000_0000;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    localparam int MEM_BYTES = 32768;
    localparam int WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_data;

    lsu_mem_port #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // RAM attached to the port: word array with a registered read.
    logic [31:0] ram [0:WORDS-1];
    logic [31:0] ram_q = 32'h0;
    assign mem_data = ram_q;

    // Reference memory, byte granular.
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    int rd_total = 0;
    int wr_total = 0;
    int bad_proto = 0;

    // RAM behaviour and port protocol monitor.
    always @(posedge clk) begin
        if (mem_wr && !mem_en) bad_proto++;
        if (mem_en && (mem_addr[1:0] != 2'b00)) bad_proto++;
        if (mem_en && (req_ready || resp_valid)) bad_proto++;
        if (mem_en) begin
            if (mem_wr) begin
                wr_total++;
                ram[mem_addr[14:2]] <= mem_wdata;
            end else begin
                rd_total++;
                ram_q <= ram[mem_addr[14:2]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        ram[addr[14:2]] = val;
        for (int b = 0; b < 4; b++) ref_mem[{addr[31:2], 2'b00} + b] = val[8*b +: 8];
    endtask

    // Reference: expected response, latency and memory traffic; applies stores.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr);
        int size;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = 1'b0;
        if (addr >= MEM_BYTES) err = 1'b1;
        if (we && f3 > 3'd2) err = 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
        if (addr % size != 0) err = 1'b1;
        rdata = 32'h0; lat = 1; nrd = 0; nwr = 0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < size; b++) ref_mem[addr + b] = wdata[8*b +: 8];
                nwr = 1;
                nrd = (size == 4) ? 0 : 1;
                lat = (size == 4) ? 2 : 4;
            end else begin
                v = 32'h0;
                for (int b = 0; b < size; b++) v[8*b +: 8] = ref_mem[addr + b];
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rdata = v; nrd = 1; lat = 3;
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold, output logic [31:0] got);
        logic e;
        logic [31:0] er;
        int elat, enr, enw, rd0, wr0, lat;
        model(we, f3, addr, wdata, e, er, elat, enr, enw);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; resp_ready = 1'b0;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        rd0 = rd_total; wr0 = wr_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 32'(lat), 32'(elat));
        check_eq("rdata", resp_rdata, er);
        check_eq("err", 32'(resp_err), 32'(e));
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
            req_addr = 32'h0000_0104;
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_rdata", resp_rdata, er);
            check_eq("hold_err", 32'(resp_err), 32'(e));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check_eq("resp_dropped", 32'(resp_valid), 32'd0);
        check_eq("reads", 32'(rd_total - rd0), 32'(enr));
        check_eq("writes", 32'(wr_total - wr0), 32'(enw));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int wr0, rd0, n, mism;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int w = 0; w < WORDS; w++) set_word(32'(w * 4), $urandom);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        set_word(32'h100, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, got);
        check_eq("t1_lw", got, 32'hDEADBEEF);

        set_word(32'h100, 32'h80FF7F01);
        run_req(1'b0, 3'b000, 32'h103, 32'h0, 0, got);
        check_eq("t2_lb", got, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h103, 32'h0, 0, got);
        check_eq("t2_lbu", got, 32'h00000080);
        run_req(1'b0, 3'b001, 32'h102, 32'h0, 0, got);
        check_eq("t2_lh", got, 32'hFFFF80FF);

        set_word(32'h100, 32'h11223344);
        run_req(1'b1, 3'b000, 32'h101, 32'h000000AB, 0, got);
        check_eq("t3_ram", ram[32'h100 >> 2], 32'h1122AB44);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, got);
        check_eq("t3_lw", got, 32'h1122AB44);

        run_req(1'b1, 3'b010, 32'h102, 32'h5555, 0, got);
        run_req(1'b0, 3'b001, 32'h101, 32'h0, 0, got);
        run_req(1'b1, 3'b011, 32'h100, 32'h5555, 0, got);
        run_req(1'b0, 3'b010, 32'h8000, 32'h0, 0, got);
        run_req(1'b0, 3'b010, 32'h7FFC, 32'h0, 0, got);
        run_req(1'b1, 3'b000, 32'h7FFF, 32'hC3, 0, got);

        run_req(1'b0, 3'b010, 32'h100, 32'h0, 5, got);

        // Reset while the SH write cycle is on the port.
        set_word(32'h300, 32'hCAFEF00D);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h302;
        req_wdata = 32'h1234; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_wr && n < 10) begin
            n++;
            @(negedge clk);
        end
        check_eq("t6_reach_wr", 32'(mem_wr), 32'd1);
        wr0 = wr_total;
        rst = 1'b1;
        #1;
        check_eq("t6_mem_en", 32'(mem_en), 32'd0);
        check_eq("t6_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("t6_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_eq("t6_no_write", 32'(wr_total - wr0), 32'd0);
        run_req(1'b0, 3'b010, 32'h300, 32'h0, 0, got);
        check_eq("t6_word", got, 32'hCAFEF00D);

        for (int t = 0; t < 300; t++) begin
            n = $urandom_range(0, 15);
            if (n == 0)      a = 32'h8000 + 32'($urandom_range(0, 7));
            else if (n == 1) a = 32'h7FF8 + 32'($urandom_range(0, 7));
            else             a = 32'h200 + 32'($urandom_range(0, 63));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    $urandom_range(0, 3), got);
        end

        mism = 0;
        for (int w = 0; w < WORDS; w++) begin
            a = {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
            if (ram[w] !== a) mism++;
        end
        check_eq("ram_vs_model", 32'(mism), 32'd0);
        check_eq("mem_protocol", 32'(bad_proto), 32'd0);
        rd0 = rd_total;
        check_eq("reads_seen", 32'(rd0 > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
